// File: rtl/div_pkg.sv
// Shared definitions for the restoring integer divider.
// Holds the FSM state encoding, the default operand width and the
// helper that sizes the iteration counter.
package div_pkg;

    localparam int DIV_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Counter must hold WIDTH-1 down to 0.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/div_int_restoring_cla_sub.sv
// cla_sub: N-bit subtractor a - b computed as a + ~b + 1 with carry lookahead.
// Ports: i_a, i_b (minuend, subtrahend), o_diff (a - b mod 2^N),
//        o_borrow (high when b > a, i.e. inverted carry out).
module cla_sub #(
    parameter int N = 9
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_diff,
    output logic         o_borrow
);

    logic [N-1:0] w_p;
    logic [N-1:0] w_g;
    logic [N:0]   w_c;
    logic         w_prod;

    // Propagate/generate against the inverted subtrahend.
    assign w_p = i_a ^ ~i_b;
    assign w_g = i_a & ~i_b;

    // Each carry is the flat lookahead sum of products:
    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, with cin = 1.
    always_comb begin
        w_c    = '0;
        w_c[0] = 1'b1;
        w_prod = 1'b1;
        for (int i = 0; i < N; i++) begin
            w_prod     = 1'b1;
            w_c[i + 1] = 1'b0;
            for (int j = i; j >= 0; j--) begin
                w_c[i + 1] = w_c[i + 1] | (w_g[j] & w_prod);
                w_prod     = w_prod & w_p[j];
            end
            w_c[i + 1] = w_c[i + 1] | w_prod;
        end
    end

    assign o_diff   = w_p ^ w_c[N-1:0];
    assign o_borrow = ~w_c[N];

endmodule

// File: rtl/div_int_restoring.sv
// div_int_restoring: iterative unsigned divider, one quotient bit per clock.
// Ports: clk/rst (sync active-high), in_valid/in_ready + dividend/divisor in,
//        out_valid/out_ready + quotient/remainder/div_by_zero out.
module div_int_restoring
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    div_state_e       r_state;
    div_state_e       w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dsr;
    logic             r_dbz;

    logic             w_accept;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic             w_take;
    logic [WIDTH-1:0] w_quo_sh;

    // Shift {R,Q} left by one: Q's msb enters R's lsb.
    assign w_rem_sh = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};

    cla_sub #(
        .N (WIDTH + 1)
    ) u_sub (
        .i_a      (w_rem_sh),
        .i_b      ({1'b0, r_dsr}),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    // R stays below D, so the bit shifted out of R is always zero; folding it
    // in keeps the step correct as a general restoring step regardless.
    assign w_take   = ~w_borrow | r_rem[WIDTH];
    assign w_quo_sh = {r_quo[WIDTH-2:0], w_take};

    assign w_accept = (r_state == ST_IDLE) && in_valid;

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = (divisor == '0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dsr   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_dsr <= divisor;
                r_cnt <= CW'(WIDTH - 1);
                if (divisor == '0) begin
                    // No iteration: result is formed directly on accept.
                    r_quo <= '1;
                    r_rem <= {1'b0, dividend};
                    r_dbz <= 1'b1;
                end else begin
                    r_quo <= dividend;
                    r_rem <= '0;
                    r_dbz <= 1'b0;
                end
            end else if (r_state == ST_CALC) begin
                r_rem <= w_take ? w_diff : w_rem_sh;
                r_quo <= w_quo_sh;
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign quotient    = r_quo;
    assign remainder   = r_rem[WIDTH-1:0];
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_int_restoring.sv
// Bench for div_int_restoring: directed and random divisions at WIDTH=8 and
// WIDTH=16, checked against plain integer division in the bench.
module tb_div_int_restoring;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8, iv8, ir8, ov8, ordy8, z8;
    logic [7:0]  dd8, dv8, q8, r8;
    logic        rst16, iv16, ir16, ov16, ordy16, z16;
    logic [15:0] dd16, dv16, q16, r16;

    int n_vec = 0;
    int n_err = 0;
    bit done16 = 1'b0;

    div_int_restoring #(.WIDTH(8)) dut8 (
        .clk (clk), .rst (rst8),
        .in_valid (iv8), .in_ready (ir8),
        .dividend (dd8), .divisor (dv8),
        .out_valid (ov8), .out_ready (ordy8),
        .quotient (q8), .remainder (r8), .div_by_zero (z8)
    );

    div_int_restoring #(.WIDTH(16)) dut16 (
        .clk (clk), .rst (rst16),
        .in_valid (iv16), .in_ready (ir16),
        .dividend (dd16), .divisor (dv16),
        .out_valid (ov16), .out_ready (ordy16),
        .quotient (q16), .remainder (r16), .div_by_zero (z16)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One WIDTH=8 division: hold = cycles out_ready stays low after out_valid,
    // noise = scramble operands and in_valid while the divider is busy.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input int hold, input bit noise);
        int         n;
        int         lat;
        logic [7:0] eq, er;
        logic       ez;
        if (b == 8'd0) begin
            eq = 8'hff; er = a; ez = 1'b1;
        end else begin
            eq = a / b; er = a % b; ez = 1'b0;
        end
        n = 0;
        while (!ir8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", ir8, 1);
        iv8 = 1'b1; dd8 = a; dv8 = b; ordy8 = (hold == 0);
        @(negedge clk);
        iv8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 50) begin
            if (noise) begin
                iv8 = 1'($urandom); dd8 = 8'($urandom); dv8 = 8'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        iv8 = 1'b0;
        chk("latency", lat, (b == 8'd0) ? 1 : 9);
        chk("in_ready_in_done", ir8, 0);
        chk("quotient", q8, eq);
        chk("remainder", r8, er);
        chk("div_by_zero", z8, ez);
        if (b != 8'd0) chk("q*d+r", longint'(q8) * b + r8, a);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_valid", ov8, 1);
            chk("hold_quotient", q8, eq);
            chk("hold_remainder", r8, er);
            chk("hold_in_ready", ir8, 0);
        end
        ordy8 = 1'b1;
        @(negedge clk);
        chk("consumed_valid", ov8, 0);
        chk("consumed_in_ready", ir8, 1);
    endtask

    initial begin
        int n;
        rst8 = 1'b1; iv8 = 1'b0; ordy8 = 1'b0; dd8 = '0; dv8 = '0;
        repeat (2) @(negedge clk);
        rst8 = 1'b0;
        chk("rst_in_ready", ir8, 1);
        chk("rst_out_valid", ov8, 0);
        chk("rst_quotient", q8, 0);
        chk("rst_remainder", r8, 0);
        chk("rst_dbz", z8, 0);

        op8(8'd100, 8'd7, 0, 1'b0);
        op8(8'd255, 8'd1, 0, 1'b0);
        op8(8'd5,   8'd9, 0, 1'b0);
        op8(8'd0,   8'd3, 0, 1'b0);
        op8(8'd200, 8'd0, 3, 1'b0);
        op8(8'd100, 8'd7, 5, 1'b0);
        op8(8'd100, 8'd7, 0, 1'b1);

        // Reset in the middle of a calculation discards it.
        iv8 = 1'b1; dd8 = 8'd100; dv8 = 8'd7;
        @(negedge clk);
        iv8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_calc_busy", ir8, 0);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        chk("mid_rst_in_ready", ir8, 1);
        chk("mid_rst_out_valid", ov8, 0);
        chk("mid_rst_quotient", q8, 0);
        chk("mid_rst_remainder", r8, 0);
        chk("mid_rst_dbz", z8, 0);
        op8(8'd9, 8'd3, 0, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom >> $urandom_range(0, 7));
            op8(a, b, $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
        end

        n = 0;
        while (!done16 && n < 60000) begin
            @(negedge clk);
            n++;
        end
        chk("w16_finished", done16, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // WIDTH=16 stream with out_ready randomised every cycle.
    initial begin
        logic [15:0] a, b, eq, er;
        logic        ez;
        int          n, lat;
        rst16 = 1'b1; iv16 = 1'b0; ordy16 = 1'b0; dd16 = '0; dv16 = '0;
        repeat (2) @(negedge clk);
        rst16 = 1'b0;
        chk("w16_rst_in_ready", ir16, 1);
        chk("w16_rst_out_valid", ov16, 0);
        for (int i = 0; i < 1500; i++) begin
            a = 16'($urandom);
            b = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom >> $urandom_range(0, 15));
            if (b == 16'd0) begin
                eq = 16'hffff; er = a; ez = 1'b1;
            end else begin
                eq = a / b; er = a % b; ez = 1'b0;
            end
            n = 0;
            while (!ir16 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("w16_in_ready_wait", ir16, 1);
            iv16 = 1'b1; dd16 = a; dv16 = b;
            @(negedge clk);
            iv16 = 1'b0; dd16 = 16'($urandom); dv16 = 16'($urandom);
            lat = 1;
            while (!ov16 && lat < 100) begin
                ordy16 = 1'($urandom);
                @(negedge clk);
                lat++;
            end
            chk("w16_latency", lat, (b == 16'd0) ? 1 : 17);
            chk("w16_quotient", q16, eq);
            chk("w16_remainder", r16, er);
            chk("w16_dbz", z16, ez);
            if (b != 16'd0) chk("w16_q*d+r", longint'(q16) * b + r16, a);
            n = 0;
            while (ov16 && n < 100) begin
                chk("w16_hold_quotient", q16, eq);
                ordy16 = 1'($urandom);
                @(negedge clk);
                n++;
            end
            chk("w16_consumed", ov16, 0);
        end
        done16 = 1'b1;
    end

endmodule
